writeback_arbiter: RTL and testbench

- Parametrised writeback stage for the out-of-order core.
- Collects results from N_FU functional-unit channels. Each cycle it grants up to NUM_CDB non-store results onto registered common data buses (CDB), which the ROB and issue queue snoop. It also grants at most one store result to the store buffer (SB) write port.
- Arbitration is round-robin with valid/ready backpressure, global flush and a saturating conflict counter.
- Sits between execute units and ROB/IQ/SB.

---
 rtl/ooo_pkg.sv | 16 +
 rtl/rr_multi_grant.sv | 61 ++++++
 rtl/writeback_arbiter.sv | 130 +++++++++++++
 tb/tb_writeback_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: writeback payload and CDB sizing.
package ooo_pkg;

  localparam int unsigned WB_DATA_W    = 32;
  localparam int unsigned WB_ROB_DEPTH = 16;
  localparam int unsigned WB_TAG_W     = $clog2(WB_ROB_DEPTH);
  // CDB broadcast ports per cycle; the ROB and issue queue size their snoop logic from this.
  localparam int unsigned CDB_PORTS    = 2;

  typedef struct packed {
    logic [WB_TAG_W-1:0]  tag;
    logic [WB_DATA_W-1:0] data;
    logic                 exc;
  } wb_pkt_t;

endpackage

// File: rtl/rr_multi_grant.sv
// Round-robin multi-grant: scans requests from ptr and grants up to MAX_GRANT of them.
module rr_multi_grant #(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_GRANT = 2
) (
  input  logic [N-1:0]                          req,
  input  logic [$clog2(N)-1:0]                  ptr,
  output logic [N-1:0]                          grant,
  output logic [MAX_GRANT-1:0][$clog2(N)-1:0]   slot_idx,
  output logic [MAX_GRANT-1:0]                  slot_vld,
  output logic                                  any_grant,
  output logic [$clog2(N)-1:0]                  last_off,
  output logic [$clog2(N)-1:0]                  next_ptr
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned GC_W  = $clog2(MAX_GRANT + 1);

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] nsum;
  logic [IDX_W-1:0] idx;
  logic [GC_W-1:0]  gcnt;

  // Scan in rotated order, fill slots in scan order, remember the offset of the last grant.
  always_comb begin
    grant     = '0;
    slot_idx  = '0;
    slot_vld  = '0;
    any_grant = 1'b0;
    last_off  = '0;
    gcnt      = '0;
    sum       = '0;
    idx       = '0;
    for (int unsigned s = 0; s < N; s++) begin
      sum = {1'b0, ptr} + SUM_W'(s);
      if (sum >= SUM_W'(N)) sum = sum - SUM_W'(N);
      idx = sum[IDX_W-1:0];
      if (req[idx] && (gcnt < GC_W'(MAX_GRANT))) begin
        grant[idx] = 1'b1;
        for (int unsigned k = 0; k < MAX_GRANT; k++) begin
          if (gcnt == GC_W'(k)) begin
            slot_idx[k] = idx;
            slot_vld[k] = 1'b1;
          end
        end
        gcnt      = gcnt + GC_W'(1);
        any_grant = 1'b1;
        last_off  = IDX_W'(s);
      end
    end
  end

  // Pointer moves to the channel just past the last grant.
  always_comb begin
    nsum = {1'b0, ptr} + SUM_W'(last_off) + SUM_W'(1);
    if (nsum >= SUM_W'(N)) nsum = nsum - SUM_W'(N);
    next_ptr = nsum[IDX_W-1:0];
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: round-robin grants of FU results onto registered CDBs and the SB write port.
module writeback_arbiter
  import ooo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WB_DATA_W,
  parameter int unsigned N_FU       = 4,
  parameter int unsigned NUM_CDB    = CDB_PORTS,
  parameter int unsigned ROB_DEPTH  = WB_ROB_DEPTH,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_i,
  input  logic [N_FU-1:0]                      fu_valid_i,
  output logic [N_FU-1:0]                      fu_ready_o,
  input  logic [N_FU-1:0][TAG_W-1:0]           fu_tag_i,
  input  logic [N_FU-1:0][DATA_WIDTH-1:0]      fu_data_i,
  input  logic [N_FU-1:0]                      fu_exc_i,
  input  logic [N_FU-1:0]                      fu_is_store_i,
  input  logic                                 sb_ready_i,
  output logic [NUM_CDB-1:0]                   cdb_valid_o,
  output logic [NUM_CDB-1:0][TAG_W-1:0]        cdb_tag_o,
  output logic [NUM_CDB-1:0][DATA_WIDTH-1:0]   cdb_data_o,
  output logic [NUM_CDB-1:0]                   cdb_exc_o,
  output logic                                 sb_valid_o,
  output logic [TAG_W-1:0]                     sb_tag_o,
  output logic [DATA_WIDTH-1:0]                sb_data_o,
  output logic [CNT_W-1:0]                     conflict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(N_FU);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IDX_W-1:0]                rr_ptr;
  logic                            gate_c;
  logic [N_FU-1:0]                 cdb_req_c, sb_req_c, cdb_grant_c, sb_grant_c;
  logic [NUM_CDB-1:0][IDX_W-1:0]   cdb_idx_c;
  logic [NUM_CDB-1:0]              cdb_slot_vld_c;
  logic [0:0][IDX_W-1:0]           sb_idx_c;
  logic [0:0]                      sb_slot_vld_c;
  logic                            cdb_any_c, sb_any_c;
  logic [IDX_W-1:0]                cdb_off_c, sb_off_c, cdb_next_c, sb_next_c, rr_next_c;
  logic                            conflict_c;

  // Nothing is accepted during flush or reset; only stores see SB backpressure.
  assign gate_c     = ~flush_i & ~rst;
  assign cdb_req_c  = fu_valid_i & ~fu_is_store_i & {N_FU{gate_c}};
  assign sb_req_c   = fu_valid_i & fu_is_store_i & {N_FU{gate_c & sb_ready_i}};
  assign fu_ready_o = cdb_grant_c | sb_grant_c;
  assign conflict_c = ~flush_i & (|(fu_valid_i & ~fu_ready_o));

  rr_multi_grant #(.N(N_FU), .MAX_GRANT(NUM_CDB)) u_cdb_grant (
    .req       (cdb_req_c),
    .ptr       (rr_ptr),
    .grant     (cdb_grant_c),
    .slot_idx  (cdb_idx_c),
    .slot_vld  (cdb_slot_vld_c),
    .any_grant (cdb_any_c),
    .last_off  (cdb_off_c),
    .next_ptr  (cdb_next_c)
  );

  rr_multi_grant #(.N(N_FU), .MAX_GRANT(1)) u_sb_grant (
    .req       (sb_req_c),
    .ptr       (rr_ptr),
    .grant     (sb_grant_c),
    .slot_idx  (sb_idx_c),
    .slot_vld  (sb_slot_vld_c),
    .any_grant (sb_any_c),
    .last_off  (sb_off_c),
    .next_ptr  (sb_next_c)
  );

  // Next pointer follows whichever grant came later in scan order.
  always_comb begin
    rr_next_c = rr_ptr;
    if (cdb_any_c && sb_any_c) rr_next_c = (sb_off_c > cdb_off_c) ? sb_next_c : cdb_next_c;
    else if (cdb_any_c)        rr_next_c = cdb_next_c;
    else if (sb_any_c)         rr_next_c = sb_next_c;
  end

  // Round-robin pointer; flush restarts the scan at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rr_ptr <= '0;
    else if (flush_i) rr_ptr <= '0;
    else              rr_ptr <= rr_next_c;
  end

  // CDB broadcast registers; payload of an idle slot is left as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_o <= '0;
      cdb_tag_o   <= '0;
      cdb_data_o  <= '0;
      cdb_exc_o   <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
        cdb_valid_o[k] <= cdb_slot_vld_c[k];
        if (cdb_slot_vld_c[k]) begin
          cdb_tag_o[k]  <= fu_tag_i[cdb_idx_c[k]];
          cdb_data_o[k] <= fu_data_i[cdb_idx_c[k]];
          cdb_exc_o[k]  <= fu_exc_i[cdb_idx_c[k]];
        end
      end
    end
  end

  // SB write register; a store's exception flag is not forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid_o <= 1'b0;
      sb_tag_o   <= '0;
      sb_data_o  <= '0;
    end else begin
      sb_valid_o <= sb_slot_vld_c[0];
      if (sb_slot_vld_c[0]) begin
        sb_tag_o  <= fu_tag_i[sb_idx_c[0]];
        sb_data_o <= fu_data_i[sb_idx_c[0]];
      end
    end
  end

  // Saturating count of cycles where a valid channel went ungranted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    conflict_cnt_o <= '0;
    else if (conflict_c && conflict_cnt_o != CNT_MAX) conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (N_FU=4, NUM_CDB=2, CNT_W=4).
module tb_writeback_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic [3:0]        fu_valid_i;
  logic [3:0]        fu_ready_o;
  logic [3:0][3:0]   fu_tag_i;
  logic [3:0][31:0]  fu_data_i;
  logic [3:0]        fu_exc_i;
  logic [3:0]        fu_is_store_i;
  logic              sb_ready_i;
  logic [1:0]        cdb_valid_o;
  logic [1:0][3:0]   cdb_tag_o;
  logic [1:0][31:0]  cdb_data_o;
  logic [1:0]        cdb_exc_o;
  logic              sb_valid_o;
  logic [3:0]        sb_tag_o;
  logic [31:0]       sb_data_o;
  logic [3:0]        conflict_cnt_o;

  int total = 0;
  int bad   = 0;

  writeback_arbiter #(.DATA_WIDTH(32), .N_FU(4), .NUM_CDB(2), .ROB_DEPTH(16), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .fu_valid_i     (fu_valid_i),
    .fu_ready_o     (fu_ready_o),
    .fu_tag_i       (fu_tag_i),
    .fu_data_i      (fu_data_i),
    .fu_exc_i       (fu_exc_i),
    .fu_is_store_i  (fu_is_store_i),
    .sb_ready_i     (sb_ready_i),
    .cdb_valid_o    (cdb_valid_o),
    .cdb_tag_o      (cdb_tag_o),
    .cdb_data_o     (cdb_data_o),
    .cdb_exc_o      (cdb_exc_o),
    .sb_valid_o     (sb_valid_o),
    .sb_tag_o       (sb_tag_o),
    .sb_data_o      (sb_data_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    fu_valid_i = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    flush_i       = 1'b0;
    fu_valid_i    = '0;
    fu_exc_i      = '0;
    fu_is_store_i = '0;
    sb_ready_i    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fu_tag_i[i]  = 4'(i + 5);
      fu_data_i[i] = 32'hD000_0000 + 32'(i);
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_cdb_valid", 64'(cdb_valid_o), 64'h0);
    check("rst_sb_valid",  64'(sb_valid_o),  64'h0);
    check("rst_cnt",       64'(conflict_cnt_o), 64'h0);
    rst = 1'b0;

    // Fairness: all four non-store channels valid.
    fu_valid_i = 4'b1111;
    #1 check("fair_ready0", 64'(fu_ready_o), 64'h3);
    tick();
    check("fair_valid1", 64'(cdb_valid_o), 64'h3);
    check("fair_tag1",   64'(cdb_tag_o),   64'h65);
    check("fair_data1",  64'(cdb_data_o[0]), 64'hD000_0000);
    check("fair_ready1", 64'(fu_ready_o),  64'hC);
    check("fair_cnt1",   64'(conflict_cnt_o), 64'h1);
    tick();
    check("fair_tag2",   64'(cdb_tag_o),   64'h87);
    check("fair_data2",  64'(cdb_data_o[1]), 64'hD000_0003);
    check("fair_cnt2",   64'(conflict_cnt_o), 64'h2);
    tick();
    check("fair_tag3",   64'(cdb_tag_o),   64'h65);
    check("fair_cnt3",   64'(conflict_cnt_o), 64'h3);

    // Asynchronous reset in the middle of traffic.
    #1 rst = 1'b1;
    #1;
    check("mid_rst_cdb_valid", 64'(cdb_valid_o), 64'h0);
    check("mid_rst_cdb_tag",   64'(cdb_tag_o),   64'h0);
    check("mid_rst_sb_valid",  64'(sb_valid_o),  64'h0);
    check("mid_rst_cnt",       64'(conflict_cnt_o), 64'h0);
    check("mid_rst_ready",     64'(fu_ready_o),  64'h0);
    @(negedge clk);
    fu_valid_i = '0;
    rst        = 1'b0;

    // Mixed: ch0 store, ch1..3 non-store.
    fu_is_store_i = 4'b0001;
    fu_valid_i    = 4'b1111;
    sb_ready_i    = 1'b1;
    #1 check("mix_ready", 64'(fu_ready_o), 64'h7);
    tick();
    check("mix_sb_valid",  64'(sb_valid_o),  64'h1);
    check("mix_sb_tag",    64'(sb_tag_o),    64'h5);
    check("mix_sb_data",   64'(sb_data_o),   64'hD000_0000);
    check("mix_cdb_valid", 64'(cdb_valid_o), 64'h3);
    check("mix_cdb_tag",   64'(cdb_tag_o),   64'h76);
    check("mix_cnt",       64'(conflict_cnt_o), 64'h1);
    // Pointer should now be 3: ch3 takes slot 0 ahead of ch1.
    fu_is_store_i = '0;
    fu_valid_i    = 4'b1010;
    #1 check("ptr3_ready", 64'(fu_ready_o), 64'hA);
    tick();
    check("ptr3_cdb_valid", 64'(cdb_valid_o), 64'h3);
    check("ptr3_cdb_tag",   64'(cdb_tag_o),   64'h68);
    check("ptr3_sb_valid",  64'(sb_valid_o),  64'h0);
    fu_valid_i = '0;

    // SB backpressure on a ch2 store.
    do_reset();
    fu_is_store_i = 4'b0100;
    fu_valid_i    = 4'b0100;
    sb_ready_i    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_ready", 64'(fu_ready_o), 64'h0);
      tick();
    end
    check("bp_cnt",      64'(conflict_cnt_o), 64'h3);
    check("bp_sb_valid", 64'(sb_valid_o), 64'h0);
    sb_ready_i = 1'b1;
    #1 check("bp_ready_up", 64'(fu_ready_o), 64'h4);
    tick();
    check("bp_sb_valid_up", 64'(sb_valid_o), 64'h1);
    check("bp_sb_tag",      64'(sb_tag_o),   64'h7);
    check("bp_cnt_hold",    64'(conflict_cnt_o), 64'h3);
    fu_valid_i = '0;
    tick();
    check("bp_sb_pulse", 64'(sb_valid_o), 64'h0);

    // Exception: ch0 non-store faulting, ch1 faulting store (pointer is 3).
    fu_valid_i    = 4'b0011;
    fu_is_store_i = 4'b0010;
    fu_exc_i      = 4'b0011;
    #1 check("exc_ready", 64'(fu_ready_o), 64'h3);
    tick();
    check("exc_cdb_valid", 64'(cdb_valid_o), 64'h1);
    check("exc_cdb_exc",   64'(cdb_exc_o),   64'h1);
    check("exc_cdb_tag",   64'(cdb_tag_o[0]), 64'h5);
    check("exc_sb_valid",  64'(sb_valid_o),  64'h1);
    check("exc_sb_tag",    64'(sb_tag_o),    64'h6);
    fu_valid_i    = '0;
    fu_is_store_i = '0;
    fu_exc_i      = '0;

    // Flush: accept ch0/ch1 at T, flush in T+1 with ch1 still valid (pointer is 2).
    fu_valid_i = 4'b0011;
    #1 check("fl_ready_pre", 64'(fu_ready_o), 64'h3);
    tick();
    flush_i    = 1'b1;
    fu_valid_i = 4'b0010;
    #1;
    check("fl_ready",      64'(fu_ready_o),  64'h0);
    check("fl_cdb_valid1", 64'(cdb_valid_o), 64'h3);
    check("fl_cdb_tag1",   64'(cdb_tag_o),   64'h65);
    tick();
    check("fl_cdb_valid2", 64'(cdb_valid_o), 64'h0);
    check("fl_sb_valid2",  64'(sb_valid_o),  64'h0);
    check("fl_cnt",        64'(conflict_cnt_o), 64'h3);
    flush_i = 1'b0;
    #1 check("fl_ready_after", 64'(fu_ready_o), 64'h2);
    tick();
    check("fl_cdb_valid3", 64'(cdb_valid_o), 64'h1);
    check("fl_cdb_tag3",   64'(cdb_tag_o[0]), 64'h6);
    fu_valid_i = '0;

    // Saturation with a 4-bit counter.
    do_reset();
    fu_valid_i = 4'b1111;
    repeat (14) tick();
    check("sat_cnt14", 64'(conflict_cnt_o), 64'hE);
    repeat (6) tick();
    check("sat_cnt20", 64'(conflict_cnt_o), 64'hF);
    fu_valid_i = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
